// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: main control sequencer for the multicycle RISC datapath.
// Walks FETCH/DECODE/execute/memory/writeback and drives every datapath select and
// strobe. Control fields are registered alongside the state (decoded from the next
// state), so each output comes straight from a flop. The exceptions are the
// reset gating and the terms that depend on this cycle's inputs: the branch
// pc_write = zero, illegal_op in DECODE, and the mem_ready handshake.
// Build option: define MEM_WAIT_EN to make FETCH, MEM_READ and MEM_WRITE hold
// until mem_ready is high. Left undefined, mem_ready is ignored.
module multicycle_control_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_J     = 6'h02,
    parameter logic [5:0] OP_ADDI  = 6'h08
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    // pc_write_br is the conditional (zero-qualified) PC load used by BRANCH;
    // mem_wait marks states that must complete a memory handshake.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_br;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       mem_wait;
    } ctrl_t;

    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.mem_wait  = 1'b1;
            end
            // Branch target (PC+4 + offset<<2) is precomputed into ALUOut here.
            S_DECODE:   c.alu_src_b = 2'b11;
            S_MEM_ADDR, S_ADDI_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
                c.mem_wait = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_write  = 1'b1;
                c.i_or_d     = 1'b1;
                c.instr_done = 1'b1;
                c.mem_wait   = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.instr_done = 1'b1;
            end
            S_EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_ALU_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 1'b1;
                c.instr_done = 1'b1;
            end
            S_ADDI_WB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a   = 1'b1;
                c.alu_op      = 2'b01;
                c.pc_source   = 2'b01;
                c.pc_write_br = 1'b1;
                c.instr_done  = 1'b1;
            end
            S_JUMP: begin
                c.pc_source  = 2'b10;
                c.pc_write   = 1'b1;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t cur, nxt;
    ctrl_t  ctrl_q;
    logic   mem_go;
    logic   hs_ok;
    logic   known_op;

`ifdef MEM_WAIT_EN
    assign mem_go = mem_ready;
`else
    logic unused_mem_ready;
    assign mem_go           = 1'b1;
    assign unused_mem_ready = mem_ready;
`endif

    assign known_op = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                      (opcode == OP_BEQ)   || (opcode == OP_J)  || (opcode == OP_ADDI);

    // Next-state selection; memory states only advance once the handshake completes.
    always_comb begin
        nxt = cur;
        case (cur)
            S_FETCH:     if (mem_go) nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nxt = S_MEM_ADDR;
                    OP_RTYPE:     nxt = S_EXECUTE;
                    OP_BEQ:       nxt = S_BRANCH;
                    OP_J:         nxt = S_JUMP;
                    OP_ADDI:      nxt = S_ADDI_EX;
                    default:      nxt = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  nxt = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (mem_go) nxt = S_MEM_WB;
            S_MEM_WB:    nxt = S_FETCH;
            S_MEM_WRITE: if (mem_go) nxt = S_FETCH;
            S_EXECUTE:   nxt = S_ALU_WB;
            S_ALU_WB:    nxt = S_FETCH;
            S_BRANCH:    nxt = S_FETCH;
            S_JUMP:      nxt = S_FETCH;
            S_ADDI_EX:   nxt = S_ADDI_WB;
            S_ADDI_WB:   nxt = S_FETCH;
            default:     nxt = S_FETCH;
        endcase
    end

    // State and control-field registers; fields are decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur    <= S_FETCH;
            ctrl_q <= decode(S_FETCH);
        end else begin
            cur    <= nxt;
            ctrl_q <= decode(nxt);
        end
    end

    // Completion-qualified strobes only fire in the cycle the memory handshake finishes.
    assign hs_ok = ~ctrl_q.mem_wait | mem_go;

    // Reset forces every strobe and select low, aborting the instruction in flight.
    assign pc_write   = ~rst & ((ctrl_q.pc_write & hs_ok) | (ctrl_q.pc_write_br & zero));
    assign ir_write   = ~rst & ctrl_q.ir_write & hs_ok;
    assign instr_done = ~rst & ctrl_q.instr_done & hs_ok;
    assign i_or_d     = ~rst & ctrl_q.i_or_d;
    assign mem_read   = ~rst & ctrl_q.mem_read;
    assign mem_write  = ~rst & ctrl_q.mem_write;
    assign reg_dst    = ~rst & ctrl_q.reg_dst;
    assign mem_to_reg = ~rst & ctrl_q.mem_to_reg;
    assign reg_write  = ~rst & ctrl_q.reg_write;
    assign alu_src_a  = ~rst & ctrl_q.alu_src_a;
    assign alu_src_b  = rst ? 2'b00 : ctrl_q.alu_src_b;
    assign alu_op     = rst ? 2'b00 : ctrl_q.alu_op;
    assign pc_source  = rst ? 2'b00 : ctrl_q.pc_source;
    assign illegal_op = ~rst & (cur == S_DECODE) & ~known_op;
    assign state      = cur;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed-vector bench for the multicycle control FSM.
// Each vector lists the expected state sequence of one instruction; per-state
// control values come from the hand-written decode table in exp_ctrl.
`timescale 1ns/1ps
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst;
    logic       mem_to_reg, reg_write, alu_src_a, instr_done, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int n_chk    = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int seq[8];

`ifdef MEM_WAIT_EN
    localparam logic MR_IDLE = 1'b1;
`else
    localparam logic MR_IDLE = 1'b0;   // ignored by the default build
`endif

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_source  (pc_source),
        .instr_done (instr_done),
        .illegal_op (illegal_op),
        .state      (state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] obs();
        return {pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal_op};
    endfunction

    function automatic logic [16:0] exp_ctrl(input int st, input logic z, input logic ill,
                                             input logic rdy);
        logic pw, iod, mrd, mw, irw, rd, m2r, rw, asa, done, hs;
        logic [1:0] asb, aop, psrc;
        {pw, iod, mrd, mw, irw, rd, m2r, rw, asa, done} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        hs = 1'b1;
`ifdef MEM_WAIT_EN
        hs = rdy;
`else
        hs = hs | rdy;
`endif
        case (st)
            0:  begin mrd = 1'b1; irw = hs; pw = hs; asb = 2'b01; end
            1:  asb = 2'b11;
            2, 10: begin asa = 1'b1; asb = 2'b10; end
            3:  begin mrd = 1'b1; iod = 1'b1; end
            4:  begin rw = 1'b1; m2r = 1'b1; done = 1'b1; end
            5:  begin mw = 1'b1; iod = 1'b1; done = hs; end
            6:  begin asa = 1'b1; aop = 2'b10; end
            7:  begin rw = 1'b1; rd = 1'b1; done = 1'b1; end
            8:  begin asa = 1'b1; aop = 2'b01; psrc = 2'b01; pw = z; done = 1'b1; end
            9:  begin psrc = 2'b10; pw = 1'b1; done = 1'b1; end
            11: begin rw = 1'b1; done = 1'b1; end
            default: ;
        endcase
        return {pw, iod, mrd, mw, irw, rd, m2r, rw, asa, asb, aop, psrc, done, ill};
    endfunction

    // Check the current state and outputs, then advance one clock.
    task automatic step(input string name, input int exp_st, input logic ill);
        #1;
        chk($sformatf("%s state", name), 32'(state), 32'(exp_st));
        chk($sformatf("%s ctrl s%0d", name, exp_st), 32'(obs()),
            32'(exp_ctrl(exp_st, zero, ill && (exp_st == 1), mem_ready)));
        done_cnt += int'(instr_done);
        @(posedge clk); #1;
    endtask

    task automatic run(input string name, input logic [5:0] op, input logic z,
                       input int n, input logic ill);
        opcode = op; zero = z; mem_ready = MR_IDLE; done_cnt = 0;
        for (int i = 0; i < n; i++) step($sformatf("%s[%0d]", name, i), seq[i], ill);
        chk({name, " done pulses"}, 32'(done_cnt), ill ? 32'd0 : 32'd1);
        #1 chk({name, " refetch"}, 32'(state), 32'd0);
    endtask

    initial begin
        rst = 1'b1; opcode = 6'h00; zero = 1'b0; mem_ready = MR_IDLE;
        #1 chk("rst outputs pre-edge", 32'(obs()), 32'd0);
        @(posedge clk); #1;
        chk("rst state", 32'(state), 32'd0);
        chk("rst outputs", 32'(obs()), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        seq = '{0, 1, 6, 7, 0, 0, 0, 0};  run("rtype", 6'h00, 1'b0, 4, 1'b0);
        seq = '{0, 1, 2, 3, 4, 0, 0, 0};  run("lw",    6'h23, 1'b0, 5, 1'b0);
        seq = '{0, 1, 2, 5, 0, 0, 0, 0};  run("sw",    6'h2B, 1'b0, 4, 1'b0);
        seq = '{0, 1, 8, 0, 0, 0, 0, 0};  run("beq_z1", 6'h04, 1'b1, 3, 1'b0);
        run("beq_z0", 6'h04, 1'b0, 3, 1'b0);
        seq = '{0, 1, 9, 0, 0, 0, 0, 0};  run("j",     6'h02, 1'b1, 3, 1'b0);
        seq = '{0, 1, 10, 11, 0, 0, 0, 0}; run("addi", 6'h08, 1'b0, 4, 1'b0);
        seq = '{0, 1, 0, 0, 0, 0, 0, 0};  run("illegal", 6'h3F, 1'b0, 2, 1'b1);

        // Reset asserted while in EXECUTE and held for two edges.
        opcode = 6'h00; zero = 1'b0; mem_ready = MR_IDLE;
        step("abort", 0, 1'b0);
        step("abort", 1, 1'b0);
        #1 chk("abort in exec", 32'(state), 32'd6);
        rst = 1'b1;
        #1 chk("abort rst comb", 32'(obs()), 32'd0);
        @(posedge clk); #1;
        chk("abort rst1 state", 32'(state), 32'd0);
        chk("abort rst1 outputs", 32'(obs()), 32'd0);
        @(posedge clk); #1;
        chk("abort rst2 state", 32'(state), 32'd0);
        chk("abort rst2 outputs", 32'(obs()), 32'd0);
        rst = 1'b0;
        seq = '{0, 1, 6, 7, 0, 0, 0, 0};  run("post_rst", 6'h00, 1'b0, 4, 1'b0);

`ifdef MEM_WAIT_EN
        // FETCH stalled two cycles, then SW with MEM_WRITE stalled three cycles.
        opcode = 6'h2B; zero = 1'b0; done_cnt = 0;
        mem_ready = 1'b0;
        step("wait_f", 0, 1'b0);
        step("wait_f", 0, 1'b0);
        mem_ready = 1'b1;
        step("wait_f", 0, 1'b0);
        step("wait_sw", 1, 1'b0);
        step("wait_sw", 2, 1'b0);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("wait_sw hold", 5, 1'b0);
        mem_ready = 1'b1;
        step("wait_sw last", 5, 1'b0);
        chk("wait_sw done pulses", 32'(done_cnt), 32'd1);
        #1 chk("wait_sw refetch", 32'(state), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
